reg_bank_dump: RTL and testbench

Debug read-out engine for `reg_bank`. On a `start` pulse it walks every architectural register through the bank's two asynchronous read ports, two registers per access, and streams the contents out one word per handshake on a valid/ready port, tagged with the register index. It sits beside the core's decode-stage read path, is muxed onto `DIR_A`/`DIR_B` only while `busy`, and feeds the debug/trace unit or a bench scoreboard.

---
 rtl/reg_bank_dump.sv | 126 ++++++++++++
 tb/tb_reg_bank_dump.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/reg_bank_dump.sv
// ============================================================================
// reg_bank_dump : streams every reg_bank register out on a valid/ready port,
//                 two registers fetched per access through the async read ports
// Revision      : 1.0
// ============================================================================
`default_nettype none

module reg_bank_dump #(
  parameter int W    = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] dir_a,
  output logic [AW-1:0] dir_b,
  input  logic [W-1:0]  doa,
  input  logic [W-1:0]  dob,
  output logic [W-1:0]  dump_data,
  output logic [AW-1:0] dump_idx,
  output logic          dump_last,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic          busy,
  output logic          done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_SEND_A = 3'd2;
  localparam logic [2:0] S_SEND_B = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] dir_a_q, dir_a_d;
  logic [AW-1:0] dir_b_q, dir_b_d;
  logic [W-1:0]  buf_a_q, buf_a_d;
  logic [W-1:0]  buf_b_q, buf_b_d;

  always_comb begin
    state_d = state_q;
    dir_a_d = dir_a_q;
    dir_b_d = dir_b_q;
    buf_a_d = buf_a_q;
    buf_b_d = buf_b_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ADDR;
          dir_a_d = '0;
          dir_b_d = AW'(1);
        end
      end
      S_ADDR: begin
        // Addresses have been stable for a full cycle; snapshot the pair.
        buf_a_d = doa;
        buf_b_d = dob;
        state_d = S_SEND_A;
      end
      S_SEND_A: begin
        if (dump_ready) state_d = S_SEND_B;
      end
      S_SEND_B: begin
        if (dump_ready) begin
          if (dir_b_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ADDR;
            dir_a_d = dir_a_q + AW'(2);
            dir_b_d = dir_b_q + AW'(2);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        dir_a_d = '0;
        dir_b_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        dir_a_d = '0;
        dir_b_d = '0;
      end
    endcase
    // Abort wins over a same-cycle handshake: the word in flight is dropped.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      dir_a_d = '0;
      dir_b_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dir_a_q <= '0;
      dir_b_q <= '0;
      buf_a_q <= '0;
      buf_b_q <= '0;
    end else begin
      state_q <= state_d;
      dir_a_q <= dir_a_d;
      dir_b_q <= dir_b_d;
      buf_a_q <= buf_a_d;
      buf_b_q <= buf_b_d;
    end
  end

  assign dir_a      = dir_a_q;
  assign dir_b      = dir_b_q;
  assign dump_valid = (state_q == S_SEND_A) || (state_q == S_SEND_B);
  assign dump_data  = (state_q == S_SEND_A) ? buf_a_q :
                      (state_q == S_SEND_B) ? buf_b_q : '0;
  assign dump_idx   = (state_q == S_SEND_A) ? dir_a_q :
                      (state_q == S_SEND_B) ? dir_b_q : '0;
  assign dump_last  = (state_q == S_SEND_B) && (dir_b_q == LAST_IDX);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_reg_bank_dump.sv
// ============================================================================
// tb_reg_bank_dump : randomized self-checking bench for reg_bank_dump
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_reg_bank_dump;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [4:0]  dir_a, dir_b;
  logic [31:0] doa, dob;
  logic [31:0] dump_data;
  logic [4:0]  dump_idx;
  logic        dump_last, dump_valid, dump_ready, busy, done;

  logic [31:0] bank [32];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign doa = bank[dir_a];
  assign dob = bank[dir_b];

  reg_bank_dump #(.W(32), .NREG(32), .AW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .dir_a(dir_a), .dir_b(dir_b), .doa(doa), .dob(dob),
    .dump_data(dump_data), .dump_idx(dump_idx), .dump_last(dump_last),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .busy(busy), .done(done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Runs one dump starting from the current negedge. The expected stream is
  // simply registers 0..31 of the bank as it stood when the dump started.
  task automatic run_dump(input int ready_pct, input int abort_at, input int rst_at,
                          input bit poke_start, output int words);
    logic [31:0] snap [32];
    logic [31:0] s_data;
    logic [4:0]  s_idx;
    logic        s_last;
    int  n, stalls, exp_idx, hs_last_n;
    bit  prev_stall, ended, do_abort, do_rst;
    for (int k = 0; k < 32; k++) snap[k] = bank[k];
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0; stalls = 0; exp_idx = 0; hs_last_n = -10;
    prev_stall = 1'b0; ended = 1'b0;
    s_data = '0; s_idx = '0; s_last = 1'b0;
    check_eq("busy_after_start", busy, 1);
    check_eq("dir_a_first", dir_a, 0);
    check_eq("dir_b_first", dir_b, 1);
    check_eq("valid_in_addr", dump_valid, 0);
    while (!ended) begin
      start = poke_start && (n == 9 || n == 29);
      check_eq("done_pulse", done, (n == hs_last_n + 1));
      if (n == hs_last_n + 1) begin
        check_eq("done_cycle", n, 48 + stalls);
        @(negedge clk);
        check_eq("busy_after_done", busy, 0);
        check_eq("valid_after_done", dump_valid, 0);
        check_eq("done_one_cycle", done, 0);
        ended = 1'b1;
      end else begin
        if (prev_stall) begin
          check_eq("hold_data", dump_data, s_data);
          check_eq("hold_idx", dump_idx, s_idx);
          check_eq("hold_last", dump_last, s_last);
        end
        if (n == 1) check_eq("first_valid", dump_valid, 1);
        if (dump_valid) begin
          if (exp_idx > 31) begin
            check_eq("extra_word", dump_valid, 0);
          end else begin
            check_eq("idx", dump_idx, exp_idx);
            check_eq("data", dump_data, snap[exp_idx]);
            check_eq("last", dump_last, (exp_idx == 31));
          end
        end
        dump_ready = ($urandom_range(0, 99) < ready_pct);
        do_abort   = dump_valid && dump_ready && (exp_idx == abort_at);
        do_rst     = dump_valid && (exp_idx == rst_at);
        abort      = do_abort;
        rst        = do_rst;
        prev_stall = dump_valid && !dump_ready;
        s_data = dump_data; s_idx = dump_idx; s_last = dump_last;
        if (dump_valid && dump_ready && !do_abort && !do_rst) begin
          if (exp_idx == 31) hs_last_n = n;
          exp_idx++;
        end
        if (dump_valid && !dump_ready) stalls++;
        @(negedge clk);
        n++;
        if (do_abort || do_rst) begin
          abort = 1'b0;
          rst   = 1'b0;
          check_eq("cancel_valid", dump_valid, 0);
          check_eq("cancel_busy", busy, 0);
          check_eq("cancel_done", done, 0);
          check_eq("cancel_dir_a", dir_a, 0);
          check_eq("cancel_dir_b", dir_b, 0);
          check_eq("cancel_data", dump_data, 0);
          check_eq("cancel_idx", dump_idx, 0);
          check_eq("cancel_last", dump_last, 0);
          for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("no_done_after_cancel", done, 0);
            check_eq("idle_after_cancel", busy, 0);
          end
          ended = 1'b1;
        end else if (n > 400) begin
          check_eq("timeout", n, 0);
          ended = 1'b1;
        end
      end
    end
    words = exp_idx;
  endtask

  initial begin
    int words;
    for (int k = 0; k < 32; k++) bank[k] = 32'(10 * k);
    rst = 1'b1; start = 1'b0; abort = 1'b0; dump_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", dump_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_dir_a", dir_a, 0);
    check_eq("rst_dir_b", dir_b, 0);
    check_eq("rst_data", dump_data, 0);
    check_eq("rst_idx", dump_idx, 0);
    check_eq("rst_last", dump_last, 0);
    rst = 1'b0;
    @(negedge clk);

    run_dump(100, -1, -1, 1'b0, words);
    check_eq("full_words", words, 32);

    run_dump(55, -1, -1, 1'b0, words);
    check_eq("backpressure_words", words, 32);

    run_dump(100, -1, -1, 1'b1, words);
    check_eq("start_busy_words", words, 32);

    run_dump(100, 7, -1, 1'b0, words);
    check_eq("abort_words", words, 7);
    run_dump(80, -1, -1, 1'b0, words);
    check_eq("after_abort_words", words, 32);

    run_dump(70, -1, 13, 1'b0, words);
    check_eq("reset_words", words, 13);
    run_dump(100, -1, -1, 1'b0, words);
    check_eq("after_reset_words", words, 32);

    run_dump(100, -1, -1, 1'b0, words);
    bank[5] = 32'hDEAD;
    run_dump(100, -1, -1, 1'b0, words);
    check_eq("b2b_words", words, 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
